// File: rtl/dog_intro_animator.sv
// dog_intro_animator: per-video-frame dog sprite sequencer (walk, sniff, jump, hide); DOG_LAUGH_EN adds the laugh sequence
module dog_intro_animator #(
  parameter logic [9:0] WALK_START_X = 10'd0,
  parameter logic [9:0] SNIFF_X = 10'd100,
  parameter logic [9:0] WALK_END_X = 10'd240,
  parameter logic [9:0] STEP_PX = 10'd2,
  parameter logic [9:0] GROUND_Y = 10'd330,
  parameter logic [9:0] JUMP_PEAK_Y = 10'd250,
  parameter logic [9:0] JUMP_STEP = 10'd4,
  parameter int FRAMES_PER_ANIM = 8,
  parameter int SNIFF_TICKS = 60
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       VS,
  input  logic       start,
  input  logic       laugh_req,
  output logic [9:0] Dog_X,
  output logic [9:0] Dog_Y,
  output logic [4:0] Frame,
  output logic       dog_hidden,
  output logic       intro_done
);
  typedef enum logic [3:0] {HIDDEN, WALK, SNIFF, JUMP_UP, JUMP_DOWN, DONE
`ifdef DOG_LAUGH_EN
    , LAUGH_UP, LAUGH, LAUGH_DOWN
`endif
  } state_t;
  state_t state;
  logic vs_d, tick, go_walk, start_pend, sniffed, anim_wrap, sniff_last;
  logic [7:0] anim_cnt, sniff_cnt;
  logic [10:0] x_sum;
  logic [9:0] x_step, y_up, y_down, peak;
  assign tick = VS & ~vs_d;
  assign go_walk = tick & (start | start_pend);
  assign anim_wrap = anim_cnt == 8'(FRAMES_PER_ANIM - 1);
  assign sniff_last = sniff_cnt == 8'(SNIFF_TICKS - 1);
  assign x_sum = {1'b0, Dog_X} + {1'b0, STEP_PX};
  assign x_step = (x_sum >= {1'b0, WALK_END_X}) ? WALK_END_X : x_sum[9:0];
  // wide compares keep the rise from underflowing below the apex
  assign y_up = ({1'b0, Dog_Y} < {1'b0, peak} + {1'b0, JUMP_STEP}) ? peak : Dog_Y - JUMP_STEP;
  assign y_down = ({1'b0, Dog_Y} + {1'b0, JUMP_STEP} >= {1'b0, GROUND_Y}) ? GROUND_Y : Dog_Y + JUMP_STEP;
`ifdef DOG_LAUGH_EN
  localparam logic [9:0] LAUGH_X = WALK_END_X >> 1;
  localparam logic [9:0] LAUGH_Y = GROUND_Y - 10'd40;
  logic laugh_pend;
  assign peak = (state == LAUGH_UP) ? LAUGH_Y : JUMP_PEAK_Y;
`else
  logic unused_laugh;
  assign unused_laugh = laugh_req;
  assign peak = JUMP_PEAK_Y;
`endif
  always_ff @(posedge vga_clk) begin
    vs_d <= VS;
    if (Reset) begin
      state <= HIDDEN;
      Dog_X <= WALK_START_X;
      Dog_Y <= GROUND_Y;
      Frame <= '0;
      dog_hidden <= 1'b1;
      intro_done <= 1'b0;
      anim_cnt <= '0;
      sniff_cnt <= '0;
      sniffed <= 1'b0;
      start_pend <= 1'b0;
`ifdef DOG_LAUGH_EN
      laugh_pend <= 1'b0;
`endif
    end else begin
      intro_done <= 1'b0;
      case (state)
        HIDDEN: begin
          start_pend <= (start_pend | start) & ~tick;
          if (go_walk) begin
            state <= WALK;
            dog_hidden <= 1'b0;
            Frame <= '0;
            anim_cnt <= '0;
          end
`ifdef DOG_LAUGH_EN
          laugh_pend <= (laugh_pend | laugh_req) & ~tick;
          if (tick && !(start || start_pend) && (laugh_req || laugh_pend)) begin
            state <= LAUGH_UP;
            Dog_X <= LAUGH_X;
            Dog_Y <= GROUND_Y;
            Frame <= 5'd8;
            dog_hidden <= 1'b0;
            anim_cnt <= '0;
          end
`endif
        end
        WALK: if (tick) begin
          Dog_X <= x_step;
          anim_cnt <= anim_wrap ? '0 : anim_cnt + 8'd1;
          if (x_step == SNIFF_X && !sniffed) begin
            state <= SNIFF;
            Frame <= 5'd4;
            sniff_cnt <= '0;
            anim_cnt <= '0;
          end else if (x_step >= WALK_END_X) begin
            state <= JUMP_UP;
            Frame <= 5'd6;
          end else if (anim_wrap) Frame <= {3'b0, Frame[1:0] + 2'd1};
        end
        SNIFF: if (tick) begin
          anim_cnt <= anim_wrap ? '0 : anim_cnt + 8'd1;
          sniff_cnt <= sniff_cnt + 8'd1;
          if (sniff_last) begin
            state <= WALK;
            sniffed <= 1'b1;
            Frame <= '0;
            anim_cnt <= '0;
          end else if (anim_wrap) Frame <= {Frame[4:1], ~Frame[0]};
        end
        JUMP_UP: if (tick) begin
          Dog_Y <= y_up;
          if (y_up == JUMP_PEAK_Y) begin
            state <= JUMP_DOWN;
            Frame <= 5'd7;
          end
        end
        JUMP_DOWN: if (tick) begin
          Dog_Y <= y_down;
          if (y_down == GROUND_Y) begin
            state <= DONE;
            dog_hidden <= 1'b1;
            intro_done <= 1'b1;
          end
        end
        DONE: begin
          state <= HIDDEN;
          Dog_X <= WALK_START_X;
          Dog_Y <= GROUND_Y;
          Frame <= '0;
          anim_cnt <= '0;
          sniff_cnt <= '0;
          sniffed <= 1'b0;
        end
`ifdef DOG_LAUGH_EN
        LAUGH_UP: if (tick) begin
          Dog_Y <= y_up;
          if (y_up == LAUGH_Y) begin
            state <= LAUGH;
            sniff_cnt <= '0;
            anim_cnt <= '0;
          end
        end
        LAUGH: if (tick) begin
          anim_cnt <= anim_wrap ? '0 : anim_cnt + 8'd1;
          sniff_cnt <= sniff_cnt + 8'd1;
          if (sniff_last) begin
            state <= LAUGH_DOWN;
            Frame <= 5'd8;
          end else if (anim_wrap) Frame <= {Frame[4:1], ~Frame[0]};
        end
        LAUGH_DOWN: if (tick) begin
          Dog_Y <= y_down;
          if (y_down == GROUND_Y) begin
            state <= HIDDEN;
            dog_hidden <= 1'b1;
            Dog_X <= WALK_START_X;
            Frame <= '0;
          end
        end
`endif
        default: state <= HIDDEN;
      endcase
    end
  end
endmodule

// File: tb/tb_dog_intro_animator.sv
// tb_dog_intro_animator: randomized VS/start timing checked against a closed-form intro timeline
module tb_dog_intro_animator;
  logic vga_clk = 1'b0;
  logic Reset = 1'b1, VS = 1'b0, start = 1'b0, laugh_req = 1'b0;
  logic [9:0] Dog_X, Dog_Y;
  logic [4:0] Frame;
  logic dog_hidden, intro_done;
  int n_cmp = 0, n_bad = 0, pulses = 0;
  dog_intro_animator dut (.vga_clk(vga_clk), .Reset(Reset), .VS(VS), .start(start), .laugh_req(laugh_req),
    .Dog_X(Dog_X), .Dog_Y(Dog_Y), .Frame(Frame), .dog_hidden(dog_hidden), .intro_done(intro_done));
  always #5 vga_clk = ~vga_clk;
  always @(negedge vga_clk) if (intro_done === 1'b1) pulses++;
  // expected outputs after the n-th tick, n=0 being the tick that leaves HIDDEN
  function automatic void model(input int n, output int x, output int y, output int f, output int h);
    x = 0; y = 330; f = 0; h = 0;
    if (n <= 50) begin x = 2 * n; f = (n == 50) ? 4 : (n / 8) % 4; end
    else if (n <= 110) begin x = 100; f = (n == 110) ? 0 : 4 + ((n - 50) / 8) % 2; end
    else if (n <= 180) begin x = 100 + 2 * (n - 110); f = (n == 180) ? 6 : ((n - 110) / 8) % 4; end
    else if (n <= 200) begin x = 240; y = 330 - 4 * (n - 180); f = (n == 200) ? 7 : 6; end
    else begin x = 240; y = 250 + 4 * (n - 200); f = 7; h = int'(n == 220); end
  endfunction
  task automatic rise();
    @(negedge vga_clk) VS = 1'b1;
    @(negedge vga_clk);
  endtask
  task automatic settle();
    repeat ($urandom_range(0, 2)) @(negedge vga_clk);
    VS = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge vga_clk);
  endtask
  task automatic pulse_start();
    @(negedge vga_clk) start = 1'b1;
    @(negedge vga_clk) start = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge vga_clk) begin Reset = 1'b1; VS = 1'b0; start = 1'b0; laugh_req = 1'b0; end
    repeat (2) @(negedge vga_clk);
    Reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if (Dog_X !== 10'd0) begin n_bad++; $display("FAIL reset_x got %0d want 0", Dog_X); end
    n_cmp++; if (Dog_Y !== 10'd330) begin n_bad++; $display("FAIL reset_y got %0d want 330", Dog_Y); end
    n_cmp++; if (Frame !== 5'd0) begin n_bad++; $display("FAIL reset_frame got %0d want 0", Frame); end
    n_cmp++; if (dog_hidden !== 1'b1) begin n_bad++; $display("FAIL reset_hidden got %b want 1", dog_hidden); end
    n_cmp++; if (intro_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", intro_done); end
    for (int i = 0; i < 4; i++) begin rise(); settle(); end
    n_cmp++; if (dog_hidden !== 1'b1) begin n_bad++; $display("FAIL idle_hidden got %b want 1", dog_hidden); end
    n_cmp++; if (Dog_X !== 10'd0) begin n_bad++; $display("FAIL idle_x got %0d want 0", Dog_X); end
    n_cmp++; if (Frame !== 5'd0) begin n_bad++; $display("FAIL idle_frame got %0d want 0", Frame); end
  endtask
  task automatic test_full_run();
    int x, y, f, h, p0;
    pulse_start();
    repeat ($urandom_range(0, 4)) @(negedge vga_clk);
    p0 = pulses;
    for (int n = 0; n <= 220; n++) begin
      rise();
      model(n, x, y, f, h);
      n_cmp++; if (Dog_X !== 10'(x)) begin n_bad++; $display("FAIL run_x tick %0d got %0d want %0d", n, Dog_X, x); end
      n_cmp++; if (Dog_Y !== 10'(y)) begin n_bad++; $display("FAIL run_y tick %0d got %0d want %0d", n, Dog_Y, y); end
      n_cmp++; if (Frame !== 5'(f)) begin n_bad++; $display("FAIL run_frame tick %0d got %0d want %0d", n, Frame, f); end
      n_cmp++; if (dog_hidden !== 1'(h)) begin n_bad++; $display("FAIL run_hidden tick %0d got %b want %0d", n, dog_hidden, h); end
      n_cmp++; if (intro_done !== 1'(h)) begin n_bad++; $display("FAIL run_done tick %0d got %b want %0d", n, intro_done, h); end
      if (n < 220) begin
        if ($urandom_range(0, 9) == 0) pulse_start();
        settle();
        n_cmp++; if (Dog_X !== 10'(x) || Dog_Y !== 10'(y) || Frame !== 5'(f))
          begin n_bad++; $display("FAIL hold_xyf tick %0d got %0d/%0d/%0d want %0d/%0d/%0d", n, Dog_X, Dog_Y, Frame, x, y, f); end
        n_cmp++; if (dog_hidden !== 1'(h) || intro_done !== 1'b0)
          begin n_bad++; $display("FAIL hold_flags tick %0d got %b/%b want %0d/0", n, dog_hidden, intro_done, h); end
      end
    end
    start = 1'b1;
    @(negedge vga_clk) start = 1'b0;
    n_cmp++; if (Dog_X !== 10'd0) begin n_bad++; $display("FAIL done_x got %0d want 0", Dog_X); end
    n_cmp++; if (Dog_Y !== 10'd330) begin n_bad++; $display("FAIL done_y got %0d want 330", Dog_Y); end
    n_cmp++; if (Frame !== 5'd0) begin n_bad++; $display("FAIL done_frame got %0d want 0", Frame); end
    n_cmp++; if (dog_hidden !== 1'b1 || intro_done !== 1'b0)
      begin n_bad++; $display("FAIL done_flags got %b/%b want 1/0", dog_hidden, intro_done); end
    n_cmp++; if (pulses - p0 != 1) begin n_bad++; $display("FAIL done_pulses got %0d want 1", pulses - p0); end
    settle();
    rise();
    n_cmp++; if (dog_hidden !== 1'b1 || Dog_X !== 10'd0)
      begin n_bad++; $display("FAIL done_start_ignored got hidden %b x %0d want 1 0", dog_hidden, Dog_X); end
    settle();
  endtask
  task automatic test_reset_mid_sniff();
    int k;
    k = int'($urandom_range(51, 109));
    pulse_start();
    for (int n = 0; n <= k; n++) begin rise(); settle(); end
    n_cmp++; if (Dog_X !== 10'd100) begin n_bad++; $display("FAIL sniff_x tick %0d got %0d want 100", k, Dog_X); end
    n_cmp++; if (Frame !== 5'(4 + ((k - 50) / 8) % 2))
      begin n_bad++; $display("FAIL sniff_frame tick %0d got %0d want %0d", k, Frame, 4 + ((k - 50) / 8) % 2); end
    @(negedge vga_clk) begin VS = 1'b1; Reset = 1'b1; end
    @(negedge vga_clk) begin Reset = 1'b0; VS = 1'b0; end
    n_cmp++; if (Dog_X !== 10'd0 || Dog_Y !== 10'd330)
      begin n_bad++; $display("FAIL mid_reset_xy got %0d/%0d want 0/330", Dog_X, Dog_Y); end
    n_cmp++; if (Frame !== 5'd0) begin n_bad++; $display("FAIL mid_reset_frame got %0d want 0", Frame); end
    n_cmp++; if (dog_hidden !== 1'b1 || intro_done !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset_flags got %b/%b want 1/0", dog_hidden, intro_done); end
    rise(); settle();
    n_cmp++; if (dog_hidden !== 1'b1) begin n_bad++; $display("FAIL mid_reset_idle got %b want 1", dog_hidden); end
    pulse_start();
    for (int n = 0; n <= 50; n++) begin rise(); settle(); end
    n_cmp++; if (Dog_X !== 10'd100 || Frame !== 5'd4)
      begin n_bad++; $display("FAIL resniff got x %0d frame %0d want 100 4", Dog_X, Frame); end
    do_reset();
  endtask
  task automatic test_start_with_tick();
    @(negedge vga_clk) begin VS = 1'b1; start = 1'b1; end
    @(negedge vga_clk) start = 1'b0;
    n_cmp++; if (dog_hidden !== 1'b0) begin n_bad++; $display("FAIL cotick_hidden got %b want 0", dog_hidden); end
    n_cmp++; if (Dog_X !== 10'd0 || Frame !== 5'd0)
      begin n_bad++; $display("FAIL cotick_xf got %0d/%0d want 0/0", Dog_X, Frame); end
    for (int n = 1; n <= 8; n++) begin settle(); rise(); end
    n_cmp++; if (Dog_X !== 10'd16) begin n_bad++; $display("FAIL cotick_x8 got %0d want 16", Dog_X); end
    n_cmp++; if (Frame !== 5'd1) begin n_bad++; $display("FAIL cotick_f8 got %0d want 1", Frame); end
    settle();
    do_reset();
  endtask
`ifdef DOG_LAUGH_EN
  task automatic test_laugh();
    int p0;
    p0 = pulses;
    @(negedge vga_clk) laugh_req = 1'b1;
    @(negedge vga_clk) laugh_req = 1'b0;
    rise();
    n_cmp++; if (Dog_X !== 10'd120 || Dog_Y !== 10'd330 || dog_hidden !== 1'b0)
      begin n_bad++; $display("FAIL laugh_entry got %0d/%0d/%b want 120/330/0", Dog_X, Dog_Y, dog_hidden); end
    for (int i = 1; i <= 10; i++) begin settle(); rise(); end
    n_cmp++; if (Dog_Y !== 10'd290) begin n_bad++; $display("FAIL laugh_peak got %0d want 290", Dog_Y); end
    for (int s = 1; s <= 59; s++) begin
      settle(); rise();
      n_cmp++; if (Frame !== 5'(8 + (s / 8) % 2) || dog_hidden !== 1'b0)
        begin n_bad++; $display("FAIL laugh_frame s %0d got %0d/%b want %0d/0", s, Frame, dog_hidden, 8 + (s / 8) % 2); end
    end
    settle(); rise();
    for (int i = 1; i <= 10; i++) begin settle(); rise(); end
    n_cmp++; if (Dog_Y !== 10'd330 || dog_hidden !== 1'b1)
      begin n_bad++; $display("FAIL laugh_end got %0d/%b want 330/1", Dog_Y, dog_hidden); end
    n_cmp++; if (pulses != p0) begin n_bad++; $display("FAIL laugh_pulses got %0d want 0", pulses - p0); end
    settle();
  endtask
`endif
  initial begin
    test_reset();
    test_full_run();
    test_full_run();
    test_reset_mid_sniff();
    test_start_with_tick();
`ifdef DOG_LAUGH_EN
    test_laugh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL timeout got no finish want finish before 3000000");
    $fatal(1);
  end
endmodule
